weight_row_loader: RTL and testbench

Transmit side of the PE-grid row-weight broadcast protocol. It takes a serial stream of filter weights through a valid/ready handshake and assembles them into full row vectors. It then issues each row to the 12x14 PE grid as one single-cycle `valid_y` pulse, carrying the row vector and its `tag_row`. It sits between the weight global buffer and the grid's weight inputs; one `start` loads the whole grid.

---
 rtl/weight_row_loader.sv | 78 +++++++
 tb/tb_weight_row_loader.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/weight_row_loader.sv
// weight_row_loader: assembles a serial weight stream into row vectors and
// broadcasts each completed row to the PE grid as a single-cycle valid_y pulse.
module weight_row_loader #(
    parameter int NUM_ROWS   = 12,
    parameter int NUM_COLS   = 14,
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_weight,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] row_weight_vals [0:NUM_COLS-1],
    output logic [ID_WIDTH-1:0]   tag_row,
    output logic                  valid_y,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = $clog2(NUM_COLS);
    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
    state_t                r_state, w_next;
    logic [CW-1:0]         r_col;
    logic [ID_WIDTH-1:0]   r_row;
    logic [DATA_WIDTH-1:0] r_stage [0:NUM_COLS-2];
    logic                  w_hs, w_row_end, w_last;
    assign w_hs      = in_valid && in_ready;
    assign w_row_end = w_hs && r_col == CW'(NUM_COLS - 1);
    assign w_last    = w_row_end && r_row == ID_WIDTH'(NUM_ROWS - 1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end
    always_comb begin
        w_next   = r_state;
        in_ready = r_state == LOAD && !abort;
        busy     = r_state != IDLE;
        done     = r_state == DONE;
        if (abort) w_next = IDLE;
        else case (r_state)
            IDLE:    w_next = start ? LOAD : IDLE;
            LOAD:    w_next = w_last ? DONE : LOAD;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (abort || (r_state == IDLE && start)) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_hs) begin
            r_col <= w_row_end ? '0 : r_col + 1'b1;
            r_row <= w_row_end ? r_row + 1'b1 : r_row;
        end
    end
    // Final word of a row bypasses staging and goes straight to the output vector.
    always_ff @(posedge clk) begin
        if (w_hs && !w_row_end) r_stage[r_col] <= in_weight;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_y         <= 1'b0;
            tag_row         <= '0;
            row_weight_vals <= '{default: '0};
        end else begin
            valid_y <= w_row_end;
            if (w_row_end) begin
                tag_row <= r_row;
                for (int c = 0; c < NUM_COLS - 1; c++) row_weight_vals[c] <= r_stage[c];
                row_weight_vals[NUM_COLS-1] <= in_weight;
            end
        end
    end
endmodule

// File: tb/tb_weight_row_loader.sv
// tb_weight_row_loader: randomized bench comparing issued rows against the
// word stream sliced into NUM_COLS-word rows.
module tb_weight_row_loader;
    localparam int R = 12, C = 14, W = 16, N = R * C;
    logic          clk = 0, rst = 1, start = 0, abort = 0, in_valid = 0;
    logic [W-1:0]  in_weight = '0;
    logic          in_ready, valid_y, busy, done;
    logic [W-1:0]  row_weight_vals [0:C-1];
    logic [3:0]    tag_row;
    int            total = 0, bad = 0, cyc = 0;
    logic [W-1:0]  st [N];
    logic [W-1:0]  a_st [N];
    int            q_tag[$], q_cyc[$];
    logic [C*W-1:0] q_vec[$];
    int            done_cnt = 0, done_tag = -1, busy_cnt = 0, hold_bad = 0;
    bit            hold_en = 0;
    logic [C*W-1:0] last_vec = '0;
    logic [3:0]    last_tag = '0;

    weight_row_loader dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_weight(in_weight), .in_valid(in_valid), .in_ready(in_ready),
        .row_weight_vals(row_weight_vals), .tag_row(tag_row),
        .valid_y(valid_y), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [C*W-1:0] cur_vec();
        logic [C*W-1:0] v;
        for (int c = 0; c < C; c++) v[c*W +: W] = row_weight_vals[c];
        return v;
    endfunction

    // Reference: row r is simply words r*C .. r*C+C-1 of the stream.
    function automatic logic [C*W-1:0] exp_row(input int r);
        logic [C*W-1:0] v;
        for (int c = 0; c < C; c++) v[c*W +: W] = st[r*C + c];
        return v;
    endfunction

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            done_tag = valid_y ? int'(tag_row) : -1;
        end
        if (valid_y) begin
            q_tag.push_back(int'(tag_row));
            q_cyc.push_back(cyc);
            q_vec.push_back(cur_vec());
            last_vec = cur_vec();
            last_tag = tag_row;
        end else if (hold_en && (cur_vec() !== last_vec || tag_row !== last_tag)) hold_bad++;
    end

    task automatic clr();
        q_tag.delete(); q_cyc.delete(); q_vec.delete();
        done_cnt = 0; done_tag = -1; busy_cnt = 0; hold_bad = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic fill(input logic [W-1:0] base, input bit rnd);
        for (int i = 0; i < N; i++)
            st[i] = rnd ? {base[15:12], 12'($urandom)} : base + W'((i / C) * 16 + i % C);
    endtask

    task automatic go();
        start = 1; step(); start = 0;
    endtask

    task automatic send(input int first, input int n, input int gap_pct, input int start_at);
        for (int i = first; i < first + n; i++) begin
            while (int'($urandom_range(99)) < gap_pct) begin in_valid = 0; start = 0; step(); end
            in_valid = 1; in_weight = st[i]; start = (i == start_at); step();
        end
        in_valid = 0; start = 0;
    endtask

    task automatic test_reset();
        #2 rst = 0; #2;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++; if (valid_y !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL reset_strobes: valid_y=%b done=%b want 0 0", valid_y, done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (tag_row !== 4'd0 || cur_vec() !== '0) begin bad++; $display("FAIL reset_data: tag=%h vec=%h want 0", tag_row, cur_vec()); end
        repeat (2) @(posedge clk);
        #3 rst = 1;
        in_valid = 1; step(); step();
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_idle: in_ready=%b busy=%b want 0 0", in_ready, busy); end
        in_valid = 0;
    endtask

    task automatic test_full_load();
        clr(); fill(16'h0000, 0);
        go(); send(0, N, 0, -1);
        total++; if (valid_y !== 1'b1 || done !== 1'b1 || tag_row !== 4'd11) begin bad++; $display("FAIL full_final: valid_y=%b done=%b tag=%0d want 1 1 11", valid_y, done, tag_row); end
        step(); step();
        total++; if (q_tag.size() != R) begin bad++; $display("FAIL full_count: got %0d want %0d", q_tag.size(), R); end
        for (int i = 0; i < q_tag.size() && i < R; i++) begin
            total++; if (q_tag[i] != i || q_vec[i] !== exp_row(i)) begin bad++; $display("FAIL full_row%0d: tag=%0d vec=%h want tag=%0d vec=%h", i, q_tag[i], q_vec[i], i, exp_row(i)); end
            if (i > 0) begin
                total++; if (q_cyc[i] - q_cyc[i-1] != C) begin bad++; $display("FAIL full_spacing%0d: got %0d want %0d", i, q_cyc[i] - q_cyc[i-1], C); end
            end
        end
        total++; if (done_cnt != 1 || done_tag != R - 1) begin bad++; $display("FAIL full_done: count=%0d tag=%0d want 1 %0d", done_cnt, done_tag, R - 1); end
        total++; if (busy_cnt != N + 1) begin bad++; $display("FAIL full_busy: got %0d want %0d", busy_cnt, N + 1); end
    endtask

    task automatic test_gaps();
        clr(); fill(16'h2000, 1);
        hold_en = 1;
        go(); send(0, N, 30, -1);
        step(); step(); step();
        hold_en = 0;
        total++; if (q_tag.size() != R) begin bad++; $display("FAIL gaps_count: got %0d want %0d", q_tag.size(), R); end
        for (int i = 0; i < q_tag.size() && i < R; i++) begin
            total++; if (q_tag[i] != i || q_vec[i] !== exp_row(i)) begin bad++; $display("FAIL gaps_row%0d: tag=%0d vec=%h want tag=%0d vec=%h", i, q_tag[i], q_vec[i], i, exp_row(i)); end
        end
        total++; if (hold_bad != 0) begin bad++; $display("FAIL gaps_hold: changed %0d times want 0", hold_bad); end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL gaps_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_start_ignored();
        clr(); fill(16'h3000, 0);
        go(); send(0, N, 0, 5 * C + 3);
        total++; if (done !== 1'b1) begin bad++; $display("FAIL restart_done: got %b want 1", done); end
        start = 1; step();
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL restart_in_done: in_ready=%b busy=%b want 0 0", in_ready, busy); end
        step(); start = 0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL restart_first_idle: in_ready=%b want 1", in_ready); end
        total++; if (q_tag.size() != R) begin bad++; $display("FAIL restart_count: got %0d want %0d", q_tag.size(), R); end
        for (int i = 0; i < q_tag.size() && i < R; i++) begin
            total++; if (q_tag[i] != i || q_vec[i] !== exp_row(i)) begin bad++; $display("FAIL restart_row%0d: tag=%0d vec=%h want tag=%0d vec=%h", i, q_tag[i], q_vec[i], i, exp_row(i)); end
        end
        clr(); fill(16'h4000, 0);
        send(0, N, 0, -1); step();
        total++; if (q_tag.size() != R) begin bad++; $display("FAIL reload_count: got %0d want %0d", q_tag.size(), R); end
        for (int i = 0; i < q_tag.size() && i < R; i++) begin
            total++; if (q_tag[i] != i || q_vec[i] !== exp_row(i)) begin bad++; $display("FAIL reload_row%0d: tag=%0d vec=%h want tag=%0d vec=%h", i, q_tag[i], q_vec[i], i, exp_row(i)); end
        end
    endtask

    task automatic test_abort();
        clr(); fill(16'h5000, 1);
        go(); send(0, 3 * C + 13, 0, -1);
        in_valid = 1; in_weight = st[3*C + 13]; abort = 1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b want 0", in_ready); end
        step(); abort = 0; in_valid = 0;
        total++; if (busy !== 1'b0 || valid_y !== 1'b0) begin bad++; $display("FAIL abort_idle: busy=%b valid_y=%b want 0 0", busy, valid_y); end
        step();
        total++; if (q_tag.size() != 3 || done_cnt != 0) begin bad++; $display("FAIL abort_rows: rows=%0d done=%0d want 3 0", q_tag.size(), done_cnt); end
        clr(); fill(16'h6000, 1);
        go(); send(0, N, 0, -1); step();
        total++; if (q_tag.size() != R) begin bad++; $display("FAIL post_abort_count: got %0d want %0d", q_tag.size(), R); end
        for (int i = 0; i < q_tag.size() && i < R; i++) begin
            total++; if (q_tag[i] != i || q_vec[i] !== exp_row(i)) begin bad++; $display("FAIL post_abort_row%0d: tag=%0d vec=%h want tag=%0d vec=%h", i, q_tag[i], q_vec[i], i, exp_row(i)); end
        end
    endtask

    task automatic test_async_reset();
        clr(); fill(16'h7000, 1);
        go(); send(0, 5 * C + 5, 0, -1);
        #2 rst = 0; #1;
        total++; if (in_ready !== 1'b0 || busy !== 1'b0 || valid_y !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL arst_ctrl: in_ready=%b busy=%b valid_y=%b done=%b want 0", in_ready, busy, valid_y, done); end
        total++; if (tag_row !== 4'd0 || cur_vec() !== '0) begin bad++; $display("FAIL arst_data: tag=%h vec=%h want 0", tag_row, cur_vec()); end
        #3 rst = 1;
        in_valid = 1; step(); step(); step();
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL arst_after: in_ready=%b busy=%b want 0 0", in_ready, busy); end
        in_valid = 0;
        total++; if (q_tag.size() != 5) begin bad++; $display("FAIL arst_rows: got %0d want 5", q_tag.size()); end
    endtask

    task automatic test_back_to_back();
        int hits;
        clr(); fill(16'h0000, 1);
        a_st = st;
        go(); send(0, N, 0, -1);
        step(); go();
        fill(16'h8000, 1);
        send(0, N, 0, -1); step();
        total++; if (q_tag.size() != 2 * R) begin bad++; $display("FAIL b2b_count: got %0d want %0d", q_tag.size(), 2 * R); end
        if (q_tag.size() > R) begin
            total++; if (q_tag[R] != 0 || q_vec[R] !== exp_row(0)) begin bad++; $display("FAIL b2b_row0: tag=%0d vec=%h want tag=0 vec=%h", q_tag[R], q_vec[R], exp_row(0)); end
            hits = 0;
            for (int c = 0; c < C; c++)
                for (int j = 0; j < N; j++) if (q_vec[R][c*W +: W] === a_st[j]) hits++;
            total++; if (hits != 0) begin bad++; $display("FAIL b2b_stale: %0d old words want 0", hits); end
            total++; if (q_tag[2*R-1] != R - 1 || q_vec[2*R-1] !== exp_row(R - 1)) begin bad++; $display("FAIL b2b_last: tag=%0d want %0d", q_tag[2*R-1], R - 1); end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
